// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS field widths, opcode constants and skid-buffer state type
package mips_pkg;

  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int TARGET_W = 26;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } buf_state_e;

endpackage

// File: rtl/pipe_skid_buffer.sv
// rtl/pipe_skid_buffer.sv - generic two-entry valid/ready skid buffer with synchronous flush
module pipe_skid_buffer
  import mips_pkg::*;
#(
  parameter int PAYLOAD_W = 64
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  buf_state_e           state;
  logic [PAYLOAD_W-1:0] head_data;
  logic [PAYLOAD_W-1:0] skid_data;
  logic                 head_valid;
  logic                 skid_valid;
  logic                 accept;
  logic                 consume;

  assign accept    = in_valid && in_ready;
  assign consume   = head_valid && out_ready;
  assign out_valid = head_valid;
  assign out_data  = head_data;

  // in_ready is a register that mirrors !skid_valid, so it stays low in FULL and during reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      head_data  <= '0;
      skid_data  <= '0;
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else if (flush) begin
      state      <= EMPTY;
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (accept) begin
            head_data  <= in_data;
            head_valid <= 1'b1;
            state      <= ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            head_data <= in_data;
          end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
            state      <= FULL;
          end else if (consume) begin
            head_valid <= 1'b0;
            state      <= EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            head_data  <= skid_data;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state      <= EMPTY;
          head_valid <= 1'b0;
          skid_valid <= 1'b0;
          in_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - MIPS IF/ID stage: skid-buffered fetch entries split into fields; IFID_STALL_COUNT_EN adds stallCount
module if_id_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                inValid,
  output logic                inReady,
  input  logic [DATA_W-1:0]   inInstr,
  input  logic [PC_W-1:0]     inPc,
  input  logic                flush,
  output logic                outValid,
  input  logic                outReady,
  output logic [PC_W-1:0]     outPc,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [REG_W-1:0]    rd,
  output logic [SHAMT_W-1:0]  shamt,
  output logic [FUNCT_W-1:0]  funct,
  output logic [IMM_W-1:0]    imm16,
  output logic [TARGET_W-1:0] target,
  output logic                isRType
`ifdef IFID_STALL_COUNT_EN
  ,
  output logic [31:0]         stallCount
`endif
);

  logic [PC_W+DATA_W-1:0] head_payload;
  logic [DATA_W-1:0]      instr;
  logic                   head_valid;

  pipe_skid_buffer #(
    .PAYLOAD_W(PC_W + DATA_W)
  ) u_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_data  ({inPc, inInstr}),
    .out_valid(head_valid),
    .out_ready(outReady),
    .out_data (head_payload)
  );

  assign outValid = head_valid;

  // An empty stage presents an all-zero word, which decodes as a NOP downstream
  assign instr = head_valid ? head_payload[DATA_W-1:0] : '0;
  assign outPc = head_valid ? head_payload[DATA_W +: PC_W] : '0;

  assign opcode  = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign shamt   = instr[10:6];
  assign funct   = instr[5:0];
  assign imm16   = instr[15:0];
  assign target  = instr[25:0];
  assign isRType = head_valid && (opcode == OP_RTYPE);

`ifdef IFID_STALL_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stallCount <= '0;
    end else if (head_valid && !outReady && (stallCount != 32'hFFFF_FFFF)) begin
      stallCount <= stallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - scoreboard bench for if_id_stage against a two-deep FIFO model
module tb_if_id_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] inInstr = '0;
  logic [31:0] inPc = '0;
  logic        flush = 1'b0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] outPc;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] target;
  logic        isRType;
`ifdef IFID_STALL_COUNT_EN
  logic [31:0] stallCount;
`endif

  entry_t      q[$];
  bit          exp_ready = 1'b0;
  logic [31:0] stall_model = '0;
  int          check_cnt = 0;
  int          pass_cnt = 0;

  logic [31:0] mi, mp;
  bit          mv;

  if_id_stage dut (
    .clock   (clock),
    .reset_n (reset_n),
    .inValid (inValid),
    .inReady (inReady),
    .inInstr (inInstr),
    .inPc    (inPc),
    .flush   (flush),
    .outValid(outValid),
    .outReady(outReady),
    .outPc   (outPc),
    .opcode  (opcode),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .shamt   (shamt),
    .funct   (funct),
    .imm16   (imm16),
    .target  (target),
    .isRType (isRType)
`ifdef IFID_STALL_COUNT_EN
    ,
    .stallCount(stallCount)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model update: entries enter on accept, everything is dropped on flush or reset
  always @(posedge clock) begin
    if (!reset_n) begin
      q.delete();
      exp_ready = 1'b0;
      stall_model = '0;
    end else begin
      if (q.size() > 0 && !outReady && stall_model != 32'hFFFF_FFFF) stall_model++;
      if (flush) begin
        q.delete();
        exp_ready = 1'b1;
      end else begin
        if (inValid && exp_ready) q.push_back(entry_t'{instr: inInstr, pc: inPc});
        exp_ready = (q.size() < 2);
      end
    end
  end

  // Monitor: compares the presented head against the oldest model entry, pops on consume
  always @(negedge clock) begin
    mv = (q.size() > 0);
    mi = mv ? q[0].instr : 32'd0;
    mp = mv ? q[0].pc : 32'd0;
    check("out_valid", {31'd0, outValid}, {31'd0, mv});
    check("in_ready", {31'd0, inReady}, {31'd0, exp_ready});
    check("out_pc", outPc, mp);
    check("opcode", {26'd0, opcode}, mi >> 26);
    check("rs", {27'd0, rs}, (mi >> 21) % 32);
    check("rt", {27'd0, rt}, (mi >> 16) % 32);
    check("rd", {27'd0, rd}, (mi >> 11) % 32);
    check("shamt", {27'd0, shamt}, (mi >> 6) % 32);
    check("funct", {26'd0, funct}, mi % 64);
    check("imm16", {16'd0, imm16}, mi % 65536);
    check("target", {6'd0, target}, mi % (1 << 26));
    check("is_rtype", {31'd0, isRType}, {31'd0, mv && ((mi >> 26) == 0)});
`ifdef IFID_STALL_COUNT_EN
    check("stall_count", stallCount, stall_model);
`endif
    if (mv && outValid && outReady && !flush) void'(q.pop_front());
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time %0t expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int n;

    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // addi $t0,$zero,-1 passes straight through with outReady held high
    inValid = 1'b1; inInstr = 32'h2008FFFF; inPc = 32'h100; outReady = 1'b1;
    tick();
    inValid = 1'b0;
    @(negedge clock);
    check("t1_valid", {31'd0, outValid}, 32'd1);
    check("t1_opcode", {26'd0, opcode}, 32'h08);
    check("t1_rs", {27'd0, rs}, 32'd0);
    check("t1_rt", {27'd0, rt}, 32'd8);
    check("t1_imm16", {16'd0, imm16}, 32'hFFFF);
    check("t1_rtype", {31'd0, isRType}, 32'd0);
    check("t1_pc", outPc, 32'h100);
    tick();
    @(negedge clock);
    check("t1_drained", {31'd0, outValid}, 32'd0);
    tick();

    // add $t0,$t1,$t2
    inValid = 1'b1; inInstr = 32'h012A4020; inPc = 32'h104;
    tick();
    inValid = 1'b0;
    @(negedge clock);
    check("t2_rtype", {31'd0, isRType}, 32'd1);
    check("t2_rs", {27'd0, rs}, 32'd9);
    check("t2_rt", {27'd0, rt}, 32'd10);
    check("t2_rd", {27'd0, rd}, 32'd8);
    check("t2_shamt", {27'd0, shamt}, 32'd0);
    check("t2_funct", {26'd0, funct}, 32'h20);
    tick();

    // Backpressure: two entries fill the buffer, the third waits for space
    outReady = 1'b0;
    inValid = 1'b1; inInstr = 32'h8C880004; inPc = 32'h200;
    tick();
    inInstr = 32'hAC890008; inPc = 32'h204;
    tick();
    inInstr = 32'h00851022; inPc = 32'h208;
    @(negedge clock);
    check("t3_full_ready", {31'd0, inReady}, 32'd0);
    check("t3_full_head_pc", outPc, 32'h200);
    tick();
    outReady = 1'b1;
    n = 0;
    while (!inReady && n < 10) begin
      tick();
      n++;
    end
    check("t3_ready_timeout", {31'd0, n < 10}, 32'd1);
    tick();
    inValid = 1'b0;
    repeat (4) tick();

    // Flush while FULL discards the same-cycle offer
    outReady = 1'b0;
    inValid = 1'b1; inInstr = 32'h24010001; inPc = 32'h300;
    tick();
    inInstr = 32'h24020002; inPc = 32'h304;
    tick();
    flush = 1'b1; inInstr = 32'h24030003; inPc = 32'h308;
    tick();
    flush = 1'b0; inValid = 1'b0;
    @(negedge clock);
    check("t4_flush_valid", {31'd0, outValid}, 32'd0);
    check("t4_flush_ready", {31'd0, inReady}, 32'd1);
    outReady = 1'b1;
    repeat (3) tick();

    // Asynchronous reset mid-stream while FULL
    outReady = 1'b0;
    inValid = 1'b1; inInstr = 32'h3C04ABCD; inPc = 32'h400;
    tick();
    inInstr = 32'h3484EF01; inPc = 32'h404;
    tick();
    inValid = 1'b0;
    reset_n = 1'b0;
    q.delete();
    exp_ready = 1'b0;
    stall_model = '0;
    #1;
    check("t5_rst_valid", {31'd0, outValid}, 32'd0);
    check("t5_rst_ready", {31'd0, inReady}, 32'd0);
    check("t5_rst_opcode", {26'd0, opcode}, 32'd0);
    check("t5_rst_imm", {16'd0, imm16}, 32'd0);
    check("t5_rst_pc", outPc, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("t5_release_ready", {31'd0, inReady}, 32'd1);
    inValid = 1'b1; inInstr = 32'h0800_0040; inPc = 32'h500; outReady = 1'b1;
    tick();
    inValid = 1'b0;
    @(negedge clock);
    check("t5_latency_valid", {31'd0, outValid}, 32'd1);
    check("t5_latency_pc", outPc, 32'h500);
    check("t5_target", {6'd0, target}, 32'h40);
    tick();

`ifdef IFID_STALL_COUNT_EN
    // Five stalled cycles, then a flush that consumes rather than stalls
    outReady = 1'b0;
    inValid = 1'b1; inInstr = 32'h2108_0001; inPc = 32'h600;
    tick();
    inValid = 1'b0;
    repeat (5) tick();
    @(negedge clock);
    check("t6_stall5", stallCount, 32'd5);
    flush = 1'b1; outReady = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clock);
    check("t6_after_flush", stallCount, 32'd5);
    tick();
`endif

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      inValid  = ($urandom_range(0, 9) < 7);
      inInstr  = $urandom;
      inPc     = $urandom & 32'hFFFF_FFFC;
      outReady = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 19) == 0);
      tick();
    end
    inValid = 1'b0; flush = 1'b0; outReady = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline stage of the MIPS core, with a valid/ready handshake on both sides.
- Accepts fetched instruction words and their PCs from fetch, buffers up to two entries (skid buffer), and presents the head instruction already split into its fields.
- The imm16 field drives the immediate sign-extension stage directly downstream; the register and control fields feed the register file and the control decoder.

Parameters:
- DATA_W, 32, instruction word width; fixed at 32 for MIPS.
- PC_W, 32, program-counter width.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  asynchronous, active-low reset.
- inValid  in  1  fetch presents a valid instruction.
- inReady  out  1  stage can accept an instruction this cycle.
- inInstr  in  DATA_W  fetched instruction word.
- inPc  in  PC_W  PC of inInstr.
- flush  in  1  synchronous kill of all buffered entries (branch/jump redirect).
- outValid  out  1  head entry valid.
- outReady  in  1  decode consumes the head entry this cycle.
- outPc  out  PC_W  PC of the head entry.
- opcode  out  6  head instr[31:26].
- rs  out  5  head instr[25:21].
- rt  out  5  head instr[20:16].
- rd  out  5  head instr[15:11].
- shamt  out  5  head instr[10:6].
- funct  out  6  head instr[5:0].
- imm16  out  16  head instr[15:0]; goes to the sign extender.
- target  out  26  head instr[25:0].
- isRType  out  1  1 when opcode == 6'h00.

Behaviour:
- Clocking and reset: one clock, `clock`. Reset is asynchronous and active-low on `reset_n`; the polarity and synchronicity are fixed.
- Storage: head register and skid register, each holding {instr, pc, valid}. State is EMPTY, ONE or FULL.
- Accept: inValid && inReady. Consume: outValid && outReady.
- EMPTY:
  - accept -> ONE, head loaded.
- ONE:
  - accept with no consume -> FULL; skid loaded.
  - accept with consume -> ONE; head replaced by the new entry.
  - consume only -> EMPTY.
- FULL:
  - consume -> ONE; skid moves to head.
  - inputs are ignored while FULL.
- inReady = !skid.valid, driven from a register. It is 0 in FULL and 0 while reset_n is low.
- outValid = head.valid.
- Latency: accepted at edge N -> outValid=1 after edge N (visible in cycle N+1) when the stage was EMPTY. Order is strictly FIFO.
- Field outputs: combinational slices of the head instruction. When outValid=0, all field outputs, outPc and isRType are forced to 0 (a NOP).
- flush: highest priority. After the edge, both entries are invalid and the state is EMPTY. An accept or consume in the same cycle is discarded; inReady=1 the next cycle.
- Reset, asserted at any time including mid-transfer:
  - immediately: state EMPTY, all stored data 0, outValid=0, inReady=0, all fields 0.
  - first edge after release: inReady=1.
- No data-dependent arithmetic is done in this stage. Sign extension belongs to the next stage.

Optional Feature:
- IFID_STALL_COUNT_EN defined:
  - adds output stallCount (32 bits).
  - increments on each cycle with outValid && !outReady; saturates at 32'hFFFFFFFF.
  - cleared only by reset; flush does not clear it.
- Undefined: the port and its logic are absent.

Decomposition:
- Shared package mips_pkg:
  - field width and position constants (OPCODE_W, REG_W, IMM_W, TARGET_W).
  - OP_RTYPE = 6'h00.
  - state enum {EMPTY, ONE, FULL}.
- One natural sub-module, pipe_skid_buffer: a generic 2-entry valid/ready buffer parameterised on payload width. It holds {pc, instr}; field slicing stays in if_id_stage.

Test Plan:
1. Reset, then push 32'h2008FFFF (addi $t0,$zero,-1) for one cycle with outReady=1 -> next cycle outValid=1, opcode=6'h08, rs=0, rt=8, imm16=16'hFFFF, isRType=0. The following cycle outValid=0.
2. Push 32'h012A4020 (add $t0,$t1,$t2) -> isRType=1, rs=9, rt=10, rd=8, shamt=0, funct=6'h20.
3. Backpressure: outReady=0, offer 3 instructions on consecutive cycles -> first two accepted, inReady=0 after the second. Then outReady=1 -> both emerge in order on back-to-back cycles, and the third is accepted when inReady returns to 1.
4. flush while FULL with inValid=1 in the same cycle -> next cycle outValid=0, inReady=1, and the offered instruction is never output.
5. reset_n low for 1 cycle mid-stream with FULL state -> outValid, inReady and all fields are 0 immediately; after release, the stage accepts new input with 1-cycle latency.
6. IFID_STALL_COUNT_EN: hold outValid=1 with outReady=0 for 5 cycles -> stallCount=5. A subsequent flush leaves it at 5.
